// File: rtl/dbg_apb_pkg.sv
// Shared definitions for the debug APB decoder: FSM state codes,
// error response patterns and the slave index field position.
package dbg_apb_pkg;

  // FSM state codes
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_RESP   = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;

  // Error patterns returned to the debug host
  localparam logic [31:0] DERR = 32'hDEAD_BEEF;  // unmapped slave index
  localparam logic [31:0] TERR = 32'hDEAD_0001;  // slave never became ready

  // Slave index field inside the upstream address
  localparam int IDX_MSB = 31;
  localparam int IDX_LSB = 28;

endpackage

// File: rtl/dbg_apb_timeout.sv
// Access-phase watchdog for the debug APB decoder. The count is cleared
// while the bridge is in SETUP and advances once per ACCESS cycle that
// ends without ready; expire is high on the last allowed ACCESS cycle.
module dbg_apb_timeout #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt;

  // Wait-cycle counter; holds once the final cycle is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (en && !expire) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/dbg_apb_decoder.sv
// Debug-port APB decoder/bridge. Routes each upstream transaction to one of
// N_SLV slaves chosen by address bits [31:28], runs SETUP/ACCESS on the
// slave side and returns one registered response strobe per transaction.
// Optional feature macro: DBG_APB_TIMEOUT_EN adds the access-phase timeout
// (TERR response); without it ACCESS waits for ready indefinitely.
//
// Upstream handshake: i_penable rises with a request and stays high until
// o_pready has been seen; o_pready is a one-cycle strobe, and a new request
// is only accepted after i_penable has been observed low, so a held request
// can never be issued twice.
module dbg_apb_decoder
  import dbg_apb_pkg::*;
#(
  parameter int N_SLV       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_penable,
  input  logic                 i_pwrite,
  input  logic [31:0]          i_paddr,
  input  logic [31:0]          i_pwdata,
  output logic                 o_pready,
  output logic [31:0]          o_prdata,
  output logic [N_SLV-1:0]     o_psel,
  output logic                 o_penable,
  output logic                 o_pwrite,
  output logic [27:0]          o_paddr,
  output logic [31:0]          o_pwdata,
  input  logic [N_SLV-1:0]     i_pready,
  input  logic [32*N_SLV-1:0]  i_prdata,
  output logic [7:0]           o_err_cnt
);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [3:0]  sel_idx;
  logic [3:0]  req_idx;
  logic        req_hit;
  logic        sel_ready;
  logic [31:0] sel_rdata;
  logic        expire;
  logic        derr;
  logic        terr;
  logic        done;

  assign req_idx = i_paddr[IDX_MSB:IDX_LSB];
  assign req_hit = ({1'b0, req_idx} < 5'(N_SLV));

  // Pick ready and read data of the latched slave; all other slaves ignored
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = 32'h0;
    for (int k = 0; k < N_SLV; k++) begin
      if (sel_idx == 4'(k)) begin
        sel_ready = i_pready[k];
        sel_rdata = i_prdata[32*k +: 32];
      end
    end
  end

  // Next-state logic and response classification
  always_comb begin
    state_nxt = state;
    derr      = 1'b0;
    terr      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_penable) begin
          if (req_hit) begin
            state_nxt = ST_SETUP;
          end else begin
            state_nxt = ST_RESP;
            derr      = 1'b1;
          end
        end
      end
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        // Ready on the final allowed cycle wins over the timeout
        if (sel_ready) begin
          state_nxt = ST_RESP;
          done      = 1'b1;
        end else if (expire) begin
          state_nxt = ST_RESP;
          terr      = 1'b1;
        end
      end
      ST_RESP:  state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!i_penable) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

`ifdef DBG_APB_TIMEOUT_EN
  logic to_clr;
  logic to_en;

  assign to_clr = (state == ST_SETUP);
  assign to_en  = (state == ST_ACCESS) && !sel_ready;

  dbg_apb_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .clr    (to_clr),
    .en     (to_en),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  // State register and registered outputs, derived from the next state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      sel_idx   <= 4'd0;
      o_pready  <= 1'b0;
      o_prdata  <= 32'h0;
      o_psel    <= '0;
      o_penable <= 1'b0;
      o_pwrite  <= 1'b0;
      o_paddr   <= 28'h0;
      o_pwdata  <= 32'h0;
      o_err_cnt <= 8'h0;
    end else begin
      state     <= state_nxt;
      o_pready  <= (state_nxt == ST_RESP);
      o_penable <= (state_nxt == ST_ACCESS);
      // Request fields are captured once and never re-sampled
      if (state == ST_IDLE && i_penable) begin
        sel_idx  <= req_idx;
        o_pwrite <= i_pwrite;
        o_paddr  <= i_paddr[27:0];
        o_pwdata <= i_pwdata;
      end
      if (state_nxt == ST_SETUP) begin
        o_psel <= N_SLV'(1) << req_idx;
      end else if (state_nxt != ST_ACCESS) begin
        o_psel <= '0;
      end
      if (derr) begin
        o_prdata <= DERR;
      end else if (terr) begin
        o_prdata <= TERR;
      end else if (done) begin
        o_prdata <= o_pwrite ? 32'h0 : sel_rdata;
      end
      if ((derr || terr) && o_err_cnt != 8'hFF) begin
        o_err_cnt <= o_err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dbg_apb_decoder.sv
// Directed testbench for dbg_apb_decoder. A transaction-level timeline model
// predicts every output on every cycle; a single compare process checks the
// DUT against it at each falling edge. Literal checks pin key results.
module tb_dbg_apb_decoder;

  localparam int N_SLV       = 4;
  localparam int TIMEOUT_CYC = 8;

  // Clock / reset and DUT signals
  logic                 i_clk = 1'b0;
  logic                 i_rst_n = 1'b1;
  logic                 i_penable = 1'b0;
  logic                 i_pwrite = 1'b0;
  logic [31:0]          i_paddr = 32'h0;
  logic [31:0]          i_pwdata = 32'h0;
  logic                 o_pready;
  logic [31:0]          o_prdata;
  logic [N_SLV-1:0]     o_psel;
  logic                 o_penable;
  logic                 o_pwrite;
  logic [27:0]          o_paddr;
  logic [31:0]          o_pwdata;
  logic [N_SLV-1:0]     i_pready = '0;
  logic [32*N_SLV-1:0]  i_prdata;
  logic [7:0]           o_err_cnt;

  always #5 i_clk = ~i_clk;

  assign i_prdata = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_F00D, 32'h5A5A_0000};

  dbg_apb_decoder #(
    .N_SLV       (N_SLV),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_penable (i_penable),
    .i_pwrite  (i_pwrite),
    .i_paddr   (i_paddr),
    .i_pwdata  (i_pwdata),
    .o_pready  (o_pready),
    .o_prdata  (o_prdata),
    .o_psel    (o_psel),
    .o_penable (o_penable),
    .o_pwrite  (o_pwrite),
    .o_paddr   (o_paddr),
    .o_pwdata  (o_pwdata),
    .i_pready  (i_pready),
    .i_prdata  (i_prdata),
    .o_err_cnt (o_err_cnt)
  );

  // Scoreboard state
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;
  logic [3:0]  exp_psel = '0;
  logic        exp_penable = 1'b0;
  logic        exp_pready = 1'b0;
  logic [31:0] exp_prdata = 32'h0;
  logic        exp_pwrite = 1'b0;
  logic [27:0] exp_paddr = 28'h0;
  logic [31:0] exp_pwdata = 32'h0;
  logic [7:0]  exp_err = 8'h0;

  // Observations from the most recent transaction
  int          seen_rdy;
  int          n_rdy;
  int          n_setup;
  logic [3:0]  psel_c1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] slave_data(input int idx);
    case (idx)
      0:       return 32'h5A5A_0000;
      1:       return 32'hCAFE_F00D;
      2:       return 32'h2222_2222;
      default: return 32'h3333_3333;
    endcase
  endfunction

  // Compare process: every output against the model, every cycle
  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("psel",    32'(o_psel),    32'(exp_psel));
      chk("penable", 32'(o_penable), 32'(exp_penable));
      chk("pready",  32'(o_pready),  32'(exp_pready));
      chk("prdata",  o_prdata,       exp_prdata);
      chk("pwrite",  32'(o_pwrite),  32'(exp_pwrite));
      chk("paddr",   32'(o_paddr),   32'(exp_paddr));
      chk("pwdata",  o_pwdata,       exp_pwdata);
      chk("err_cnt", 32'(o_err_cnt), 32'(exp_err));
    end
  end

  // Driver + timeline model for one upstream transaction.
  // Cycle 0 presents the request; cycle c begins 1 ns after the c-th edge.
  // waits: slave wait cycles; hold: extra cycles i_penable stays high after
  // the response; drop: i_penable only high in cycle 0; abort_at: cycle at
  // which reset is asserted (-1 for none).
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input int waits, input int hold, input bit drop, input int abort_at);
    int          idx;
    bit          derr;
    bit          terr;
    int          n_acc;
    int          last_acc;
    int          resp;
    int          end_c;
    logic [3:0]  oh;
    logic [31:0] rdata;
    idx  = int'(addr[31:28]);
    derr = (idx >= N_SLV);
    terr = 1'b0;
    if (derr) begin
      last_acc = 0;
      resp     = 1;
    end else begin
      n_acc = waits + 1;
`ifdef DBG_APB_TIMEOUT_EN
      if (n_acc > TIMEOUT_CYC) begin
        n_acc = TIMEOUT_CYC;
        terr  = 1'b1;
      end
`endif
      last_acc = 1 + n_acc;
      resp     = last_acc + 1;
    end
    end_c = resp + (drop ? 0 : hold) + 1;
    oh    = derr ? 4'b0000 : 4'(1 << idx);
    rdata = derr ? 32'hDEAD_BEEF : terr ? 32'hDEAD_0001 : wr ? 32'h0 : slave_data(idx);
    seen_rdy = 0;
    n_rdy    = 0;
    n_setup  = 0;
    psel_c1  = 4'hx;
    for (int c = 0; c <= end_c; c++) begin
      @(posedge i_clk);
      #1;
      if (c == abort_at) begin
        i_rst_n     = 1'b0;
        i_penable   = 1'b0;
        i_pready    = '0;
        exp_psel    = '0;
        exp_penable = 1'b0;
        exp_pready  = 1'b0;
        exp_prdata  = 32'h0;
        exp_pwrite  = 1'b0;
        exp_paddr   = 28'h0;
        exp_pwdata  = 32'h0;
        exp_err     = 8'h0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        return;
      end
      i_penable = drop ? (c == 0) : (c <= resp + hold);
      i_pwrite  = (c == 0) ? wr : ~wr;
      i_paddr   = (c == 0) ? addr : ~addr;
      i_pwdata  = (c == 0) ? wd : ~wd;
      i_pready  = ~oh | ((!derr && c >= 2 + waits) ? oh : 4'b0000);
      exp_psel    = (c >= 1 && c <= last_acc) ? oh : 4'b0000;
      exp_penable = !derr && c >= 2 && c <= last_acc;
      exp_pready  = (c == resp);
      if (c == 1) begin
        exp_pwrite = wr;
        exp_paddr  = addr[27:0];
        exp_pwdata = wd;
      end
      if (c == resp) begin
        exp_prdata = rdata;
        if ((derr || terr) && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
      end
      if (o_pready) begin
        n_rdy++;
        if (seen_rdy == 0) seen_rdy = c;
      end
      if (o_psel != '0 && !o_penable) n_setup++;
      if (c == 1) psel_c1 = o_psel;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset phase
    #2;
    i_rst_n = 1'b0;
    chk_en  = 1'b1;
    #1;
    chk("rst_prdata",  o_prdata,         32'h0);
    chk("rst_psel",    32'(o_psel),      32'h0);
    chk("rst_err_cnt", 32'(o_err_cnt),   32'h0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk);

    // Zero-wait read of slave 1
    run_txn(1'b0, 32'h1000_0010, 32'h0, 0, 0, 1'b0, -1);
    chk("t1_lat",   32'(seen_rdy), 32'd3);
    chk("t1_psel",  32'(psel_c1),  32'h2);
    chk("t1_paddr", 32'(o_paddr),  32'h10);
    chk("t1_rdata", o_prdata,      32'hCAFE_F00D);

    // Write to slave 2 with three wait cycles
    run_txn(1'b1, 32'h2000_0004, 32'h1234_5678, 3, 0, 1'b0, -1);
    chk("t2_lat",    32'(seen_rdy), 32'd6);
    chk("t2_pwrite", 32'(o_pwrite), 32'd1);
    chk("t2_pwdata", o_pwdata,      32'h1234_5678);
    chk("t2_rdata",  o_prdata,      32'h0);

    // Unmapped slave index
    run_txn(1'b0, 32'h7000_0000, 32'h0, 0, 0, 1'b0, -1);
    chk("t3_lat",   32'(seen_rdy),  32'd1);
    chk("t3_rdata", o_prdata,       32'hDEAD_BEEF);
    chk("t3_err",   32'(o_err_cnt), 32'd1);
    chk("t3_setup", 32'(n_setup),   32'd0);

    // Slave 0 never ready
`ifdef DBG_APB_TIMEOUT_EN
    run_txn(1'b0, 32'h0000_0040, 32'h0, 100000, 0, 1'b0, -1);
    chk("t4_lat",   32'(seen_rdy),  32'd10);
    chk("t4_rdata", o_prdata,       32'hDEAD_0001);
    chk("t4_err",   32'(o_err_cnt), 32'd2);
`else
    run_txn(1'b0, 32'h0000_0040, 32'h0, 100000, 0, 1'b0, 1001);
    chk("t4_no_rsp", 32'(n_rdy), 32'd0);
`endif

    // Request held high for 10 cycles after the response
    run_txn(1'b0, 32'h3000_0100, 32'h0, 1, 10, 1'b0, -1);
    chk("t5_rdy_cnt", 32'(n_rdy),   32'd1);
    chk("t5_setups",  32'(n_setup), 32'd1);
    chk("t5_rdata",   o_prdata,     32'h3333_3333);

    // Timeout boundary: ready on the final allowed cycle, then one too late
    run_txn(1'b0, 32'h0000_0008, 32'h0, 7, 0, 1'b0, -1);
    chk("t6_rdata", o_prdata, 32'h5A5A_0000);
    run_txn(1'b0, 32'h0000_000C, 32'h0, 8, 0, 1'b0, -1);

    // Request dropped right after cycle 0
    run_txn(1'b0, 32'h2000_0200, 32'h0, 2, 0, 1'b1, -1);
    chk("t7_rdy_cnt", 32'(n_rdy), 32'd1);
    chk("t7_rdata",   o_prdata,   32'h2222_2222);

    // Write to an unmapped slave
    run_txn(1'b1, 32'hF000_0008, 32'hAAAA_5555, 0, 2, 1'b0, -1);
    chk("t8_rdata", o_prdata, 32'hDEAD_BEEF);

    // Reset during ACCESS, then a normal read
    run_txn(1'b0, 32'h2000_0300, 32'h0, 50, 0, 1'b0, 3);
    chk("t9_psel",    32'(o_psel),    32'h0);
    chk("t9_penable", 32'(o_penable), 32'h0);
    chk("t9_err",     32'(o_err_cnt), 32'h0);
    run_txn(1'b0, 32'h1000_0020, 32'h0, 0, 0, 1'b0, -1);
    chk("t9_lat",   32'(seen_rdy), 32'd3);
    chk("t9_rdata", o_prdata,      32'hCAFE_F00D);

    // Error counter saturation
    for (int i = 0; i < 260; i++) begin
      run_txn(i[0], 32'h4000_0000 | 32'(i * 4), 32'(i), 0, 0, 1'b0, -1);
    end
    chk("sat_err", 32'(o_err_cnt), 32'hFF);

    repeat (2) @(posedge i_clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
